// File: rtl/calc_pkg.sv
// ---------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the calculator practice controller: the sequencer
// state encoding (also shown on the debug LEDs), operand/result byte counts
// and the flag pattern reported when the arithmetic unit times out.
// ---------------------------------------------------------------------------
package calc_pkg;

  // State encoding is visible on state_dbg, so the values are fixed.
  typedef enum logic [2:0] {
    LOAD_A = 3'd0,
    LOAD_B = 3'd1,
    START  = 3'd2,
    WAIT   = 3'd3,
    SHOW   = 3'd4
  } calc_state_t;

  localparam int BYTES_PER_OPERAND = 4;
  localparam int RESULT_BYTES      = 4;
  localparam int NBYTES            = 2 * BYTES_PER_OPERAND;

  // Reported in place of real flags when op_done never arrived.
  localparam logic [4:0] FLAGS_ERR = 5'b11111;

  // True while the operator is keying in operand bytes.
  function automatic logic is_loading(input calc_state_t s);
    return (s == LOAD_A) || (s == LOAD_B);
  endfunction

endpackage

// File: rtl/calc_timeout_counter.sv
// ---------------------------------------------------------------------------
// calc_timeout_counter
// Cycle counter used by the sequencer to bound its wait for op_done.
//
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous, active-high reset (count -> 0)
//   clear     in   synchronous clear, has priority over enable
//   enable    in   count up by one on the next edge
//   terminal  out  high while the count equals TIMEOUT-1
// ---------------------------------------------------------------------------
module calc_timeout_counter #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Clear wins over enable so a restart during a wait always starts fresh.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign terminal = (count_q == LAST);

endmodule

// File: rtl/calc_sequencer.sv
// ---------------------------------------------------------------------------
// calc_sequencer
// Top-level controller for the calculator practice datapath. Steps the
// operator through eight operand bytes (A = bytes 0-3, B = bytes 4-7),
// fires a one-cycle start at the arithmetic unit, waits for op_done with a
// timeout, latches the special-case flags and then walks the result display
// one byte per enter press.
//
// Ports:
//   clk              in   system clock
//   reset            in   asynchronous, active-high reset
//   enter_pulse      in   single-cycle debounced enter press
//   restart          in   single-cycle abort, back to operand entry
//   op_done          in   arithmetic completion (only looked at in WAIT)
//   op_flags[4:0]    in   special-case flags, valid with op_done
//   loaddata         out  high during operand entry
//   load_we          out  operand byte write strobe
//   byte_sel[2:0]    out  operand byte index (bit2 selects B)
//   op_start         out  one-cycle start to the arithmetic unit
//   result_sel[1:0]  out  result byte shown on the displays
//   inputdata_ready  out  high while the result is displayed
//   casesspecial[4:0] out latched special-case flags
//   err_timeout      out  sticky timeout indication
//   state_dbg[2:0]   out  current state for the debug LEDs
// ---------------------------------------------------------------------------
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enter_pulse,
  input  logic       restart,
  input  logic       op_done,
  input  logic [4:0] op_flags,
  output logic       loaddata,
  output logic       load_we,
  output logic [2:0] byte_sel,
  output logic       op_start,
  output logic [1:0] result_sel,
  output logic       inputdata_ready,
  output logic [4:0] casesspecial,
  output logic       err_timeout,
  output logic [2:0] state_dbg
);

  localparam logic [2:0] LAST_A_BYTE = 3'(BYTES_PER_OPERAND - 1);
  localparam logic [2:0] LAST_BYTE   = 3'(NBYTES - 1);

  calc_state_t state_q, state_d;
  logic [2:0]  byte_cnt_q, byte_cnt_d;
  logic [1:0]  result_sel_q, result_sel_d;
  logic [4:0]  flags_q, flags_d;
  logic        err_q, err_d;

  logic timeout_clear;
  logic timeout_enable;
  logic timeout_hit;

  // The counter restarts from zero on the START cycle and only advances
  // while genuinely waiting, so its terminal count marks TIMEOUT wait cycles.
  assign timeout_clear  = restart || (state_q == START);
  assign timeout_enable = (state_q == WAIT) && !op_done;

  calc_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .clear    (timeout_clear),
    .enable   (timeout_enable),
    .terminal (timeout_hit)
  );

  // Next-state logic. restart overrides everything else on the same cycle;
  // enter presses outside entry/show have no effect and are not remembered.
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    result_sel_d = result_sel_q;
    flags_d      = flags_q;
    err_d        = err_q;

    if (restart) begin
      state_d      = LOAD_A;
      byte_cnt_d   = '0;
      result_sel_d = '0;
      flags_d      = '0;
      err_d        = 1'b0;
    end else begin
      case (state_q)
        LOAD_A: begin
          if (enter_pulse) begin
            byte_cnt_d = byte_cnt_q + 3'd1;
            if (byte_cnt_q == LAST_A_BYTE) begin
              state_d = LOAD_B;
            end
          end
        end
        LOAD_B: begin
          if (enter_pulse) begin
            if (byte_cnt_q == LAST_BYTE) begin
              byte_cnt_d = '0;
              state_d    = START;
            end else begin
              byte_cnt_d = byte_cnt_q + 3'd1;
            end
          end
        end
        START: begin
          state_d = WAIT;
        end
        WAIT: begin
          // A completion on the terminal cycle still counts as success.
          if (op_done) begin
            flags_d      = op_flags;
            err_d        = 1'b0;
            result_sel_d = '0;
            state_d      = SHOW;
          end else if (timeout_hit) begin
            flags_d = FLAGS_ERR;
            err_d   = 1'b1;
            state_d = SHOW;
          end
        end
        SHOW: begin
          if (enter_pulse) begin
            result_sel_d = result_sel_q + 2'd1;
          end
        end
        default: begin
          state_d = LOAD_A;
        end
      endcase
    end
  end

  // All controller state lives in this one register block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= LOAD_A;
      byte_cnt_q   <= '0;
      result_sel_q <= '0;
      flags_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      result_sel_q <= result_sel_d;
      flags_q      <= flags_d;
      err_q        <= err_d;
    end
  end

  // Output decode. load_we follows enter directly so the byte lands in the
  // same cycle as the press, but never on a cycle that is being aborted.
  always_comb begin
    loaddata        = is_loading(state_q);
    load_we         = is_loading(state_q) && enter_pulse && !restart;
    op_start        = (state_q == START);
    inputdata_ready = (state_q == SHOW);
  end

  assign byte_sel     = byte_cnt_q;
  assign result_sel   = result_sel_q;
  assign casesspecial = flags_q;
  assign err_timeout  = err_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_calc_sequencer
// Self-checking bench for calc_sequencer with TIMEOUT=16. A phase-level
// model (entry / start / wait / show, byte and wait-cycle tallies) predicts
// every output each cycle; directed steps cover the operator scenarios and
// are followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_calc_sequencer;

  localparam int TIMEOUT = 16;
  localparam int PH_ENTRY = 0;
  localparam int PH_START = 1;
  localparam int PH_WAIT  = 2;
  localparam int PH_SHOW  = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       enter_pulse;
  logic       restart;
  logic       op_done;
  logic [4:0] op_flags;
  logic       loaddata;
  logic       load_we;
  logic [2:0] byte_sel;
  logic       op_start;
  logic [1:0] result_sel;
  logic       inputdata_ready;
  logic [4:0] casesspecial;
  logic       err_timeout;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;

  int         m_phase;
  int         m_entered;
  int         m_waited;
  int         m_rsel;
  logic [4:0] m_flags;
  logic       m_err;

  calc_sequencer #(
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .enter_pulse     (enter_pulse),
    .restart         (restart),
    .op_done         (op_done),
    .op_flags        (op_flags),
    .loaddata        (loaddata),
    .load_we         (load_we),
    .byte_sel        (byte_sel),
    .op_start        (op_start),
    .result_sel      (result_sel),
    .inputdata_ready (inputdata_ready),
    .casesspecial    (casesspecial),
    .err_timeout     (err_timeout),
    .state_dbg       (state_dbg)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Guard against a stuck run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic modelClear();
    m_phase   = PH_ENTRY;
    m_entered = 0;
    m_waited  = 0;
    m_rsel    = 0;
    m_flags   = 5'd0;
    m_err     = 1'b0;
  endtask

  function automatic int expStateDbg();
    case (m_phase)
      PH_ENTRY: return (m_entered < 4) ? 0 : 1;
      PH_START: return 2;
      PH_WAIT:  return 3;
      default:  return 4;
    endcase
  endfunction

  // Compare every output against the model's view of the current cycle.
  task automatic checkAll(input logic en, input logic rs);
    checkOutput("loaddata", 32'(loaddata), 32'(m_phase == PH_ENTRY));
    checkOutput("load_we", 32'(load_we), 32'((m_phase == PH_ENTRY) && en && !rs));
    checkOutput("byte_sel", 32'(byte_sel), 32'(m_entered));
    checkOutput("op_start", 32'(op_start), 32'(m_phase == PH_START));
    checkOutput("result_sel", 32'(result_sel), 32'(m_rsel));
    checkOutput("inputdata_ready", 32'(inputdata_ready), 32'(m_phase == PH_SHOW));
    checkOutput("casesspecial", 32'(casesspecial), 32'(m_flags));
    checkOutput("err_timeout", 32'(err_timeout), 32'(m_err));
    checkOutput("state_dbg", 32'(state_dbg), 32'(expStateDbg()));
  endtask

  // Advance the model by one clock edge given that cycle's inputs.
  task automatic modelStep(input logic en, input logic rs, input logic dn,
                           input logic [4:0] fl);
    if (rs) begin
      modelClear();
    end else begin
      case (m_phase)
        PH_ENTRY: begin
          if (en) begin
            m_entered++;
            if (m_entered == 8) begin
              m_entered = 0;
              m_phase   = PH_START;
            end
          end
        end
        PH_START: begin
          m_phase  = PH_WAIT;
          m_waited = 0;
        end
        PH_WAIT: begin
          if (dn) begin
            m_flags = fl;
            m_err   = 1'b0;
            m_rsel  = 0;
            m_phase = PH_SHOW;
          end else if (m_waited == TIMEOUT - 1) begin
            m_flags = 5'b11111;
            m_err   = 1'b1;
            m_phase = PH_SHOW;
          end else begin
            m_waited++;
          end
        end
        default: begin
          if (en) m_rsel = (m_rsel + 1) % 4;
        end
      endcase
    end
  endtask

  // One clock cycle: drive on the falling edge, check, then step the model.
  task automatic applyStimulus(input logic en, input logic rs, input logic dn,
                               input logic [4:0] fl);
    @(negedge clk);
    enter_pulse = en;
    restart     = rs;
    op_done     = dn;
    op_flags    = fl;
    #1;
    checkAll(en, rs);
    @(posedge clk);
    modelStep(en, rs, dn, fl);
  endtask

  task automatic enterOperands();
    repeat (8) applyStimulus(1'b1, 1'b0, 1'b0, 5'd0);
  endtask

  initial begin
    int         n;
    logic       seen;
    logic [1:0] rsel_seq [5];

    rsel_seq[0] = 2'd1;
    rsel_seq[1] = 2'd2;
    rsel_seq[2] = 2'd3;
    rsel_seq[3] = 2'd0;
    rsel_seq[4] = 2'd1;

    reset       = 1'b1;
    enter_pulse = 1'b0;
    restart     = 1'b0;
    op_done     = 1'b0;
    op_flags    = 5'd0;
    modelClear();

    // Reset values.
    @(negedge clk);
    #1;
    checkAll(1'b0, 1'b0);
    reset = 1'b0;

    // Full entry, enter ignored in START/WAIT, done three cycles after start.
    $display("[TB] operand entry and normal completion");
    enterOperands();
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 5'b00100);
    #1;
    checkOutput("done_ready", 32'(inputdata_ready), 32'd1);
    checkOutput("done_flags", 32'(casesspecial), 32'(5'b00100));
    checkOutput("done_err", 32'(err_timeout), 32'd0);

    // Result byte walk.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 5'd0);
      #1;
      checkOutput("show_rsel", 32'(result_sel), 32'(rsel_seq[i]));
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 5'd0);

    // Timeout: SHOW after exactly TIMEOUT wait cycles.
    $display("[TB] timeout");
    enterOperands();
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0);
    n    = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 5'd0);
      n++;
      #1;
      if (inputdata_ready) seen = 1'b1;
    end
    checkOutput("timeout_seen", 32'(seen), 32'd1);
    checkOutput("timeout_latency", 32'(n), 32'(TIMEOUT));
    checkOutput("timeout_flags", 32'(casesspecial), 32'(5'b11111));
    checkOutput("timeout_err", 32'(err_timeout), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 5'd0);

    // op_done on the terminal wait cycle wins.
    $display("[TB] late completion on terminal cycle");
    enterOperands();
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0);
    repeat (TIMEOUT - 1) applyStimulus(1'b0, 1'b0, 1'b0, 5'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 5'b01010);
    #1;
    checkOutput("edge_ready", 32'(inputdata_ready), 32'd1);
    checkOutput("edge_flags", 32'(casesspecial), 32'(5'b01010));
    checkOutput("edge_err", 32'(err_timeout), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 5'd0);

    // restart + enter together in LOAD_B at byte 5.
    $display("[TB] restart behaviour");
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b0, 5'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd0);
    #1;
    checkOutput("rs_byte_sel", 32'(byte_sel), 32'd0);
    checkOutput("rs_state", 32'(state_dbg), 32'd0);

    // restart in WAIT, then a late op_done is ignored.
    enterOperands();
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 5'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 5'b00111);
    #1;
    checkOutput("late_done_ready", 32'(inputdata_ready), 32'd0);
    checkOutput("late_done_flags", 32'(casesspecial), 32'd0);

    // Asynchronous reset in the middle of WAIT.
    $display("[TB] async reset");
    enterOperands();
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    enter_pulse = 1'b0;
    restart     = 1'b0;
    op_done     = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    modelClear();
    checkAll(1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0);
    #1;
    checkOutput("post_reset_byte", 32'(byte_sel), 32'd1);

    // Random traffic, frequent completions.
    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 29) == 0),
                    1'($urandom_range(0, 5) == 0), 5'($urandom));
    end

    // Random traffic, rare completions so timeouts occur.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 59) == 0),
                    1'($urandom_range(0, 24) == 0), 5'($urandom));
    end

    enter_pulse = 1'b0;
    restart     = 1'b0;
    op_done     = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
